// File: rtl/falu_i2fp_iter.sv
// Iterative integer-to-floating-point converter for the FALU conversion path.
// A coarse/fine normaliser left-aligns the magnitude over several cycles, then
// one rounding cycle packs a single (NaN-boxed) or double result.
module falu_i2fp_iter #(
  parameter int XLEN       = 64,
  parameter int SHIFT_STEP = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] INPUT,
  input  logic [2:0]      Rounding_Mode,
  input  logic            IsDouble,
  input  logic            IsWord,
  input  logic            Is_Unsigned,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [63:0]     OUTPUT,
  output logic            INEXACT,
  output logic            RM_ERR
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t            state_q;
  logic [XLEN-1:0]   mag_q;
  logic [7:0]        exp_q;
  logic              sign_q;
  logic              dbl_q;
  logic              zero_q;
  logic [2:0]        rm_q;
  logic              out_valid_q;
  logic [63:0]       output_q;
  logic              inexact_q;
  logic              rm_err_q;

  logic [XLEN-1:0]   opnd_d;
  logic              sign_d;
  logic [XLEN-1:0]   mag_d;
  logic [63:0]       aligned_d;

  // Round a left-aligned 64-bit magnitude (MSB set) and pack the result.
  // Returns {inexact, result}. Reserved rounding modes fall back to RNE.
  function automatic logic [64:0] fp_round(input logic [63:0] m,
                                           input logic [7:0]  e,
                                           input logic        s,
                                           input logic [2:0]  rm,
                                           input logic        dbl);
    logic [52:0] mant;
    logic        g;
    logic        st;
    logic        inc;
    logic        carry;
    logic [53:0] sum;
    logic [10:0] be;
    logic [63:0] res;
    if (dbl) begin
      mant = m[63:11];
      g    = m[10];
      st   = |m[9:0];
    end else begin
      mant = {29'b0, m[63:40]};
      g    = m[39];
      st   = |m[38:0];
    end
    case (rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = s & (g | st);
      3'b011:  inc = ~s & (g | st);
      3'b100:  inc = g;
      default: inc = g & (st | mant[0]);
    endcase
    sum   = {1'b0, mant} + 54'(inc);
    // On carry-out the sum is exactly 1.0 * 2^M, so its fraction bits are zero.
    carry = dbl ? sum[53] : sum[24];
    be    = 11'(e) + 11'(carry) + (dbl ? 11'd1023 : 11'd127);
    if (dbl) res = {s, be, sum[51:0]};
    else     res = {32'hFFFF_FFFF, s, be[7:0], sum[22:0]};
    return {g | st, res};
  endfunction

  // Operand extraction: optional 32-bit word view, then sign/magnitude split.
  always_comb begin
    opnd_d = INPUT;
    if (XLEN == 64 && IsWord) begin
      if (Is_Unsigned) opnd_d = XLEN'(INPUT[31:0]);
      else             opnd_d = XLEN'(signed'(INPUT[31:0]));
    end
    sign_d    = ~Is_Unsigned & opnd_d[XLEN-1];
    mag_d     = sign_d ? (~opnd_d + 1'b1) : opnd_d;
    aligned_d = 64'(mag_q) << (64 - XLEN);
  end

  // Control FSM with normaliser datapath and registered result/flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      output_q    <= 64'd0;
      inexact_q   <= 1'b0;
      rm_err_q    <= 1'b0;
    end else if (FLUSH) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            exp_q   <= 8'(XLEN - 1);
            dbl_q   <= IsDouble;
            rm_q    <= Rounding_Mode;
            zero_q  <= (mag_d == '0);
            state_q <= (mag_d == '0) ? ROUND : NORM;
          end
        end
        NORM: begin
          if (mag_q[XLEN-1]) begin
            state_q <= ROUND;
          end else if (mag_q[XLEN-1 -: SHIFT_STEP] == '0) begin
            mag_q <= mag_q << SHIFT_STEP;
            exp_q <= exp_q - 8'(SHIFT_STEP);
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        ROUND: begin
          if (zero_q) begin
            output_q  <= dbl_q ? 64'd0 : 64'hFFFF_FFFF_0000_0000;
            inexact_q <= 1'b0;
          end else begin
            {inexact_q, output_q} <= fp_round(aligned_d, exp_q, sign_q, rm_q, dbl_q);
          end
          rm_err_q    <= (rm_q > 3'd4);
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = out_valid_q;
  assign OUTPUT    = output_q;
  assign INEXACT   = inexact_q;
  assign RM_ERR    = rm_err_q;

endmodule
